// File: rtl/bid_controller_n.sv
// N-bidder auction controller: host lock/unlock with timed key lockout, per-bidder bid/retract bookkeeping.
// Define BIDS_TIE_LOWEST_EN to award a tie at the top total to the lowest-index bidder instead of nobody.
module bid_controller_n #(
  parameter int N_BIDDERS = 3,
  parameter int BID_W     = 16,
  parameter int BAL_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BIDDERS-1:0]         bid,
  input  logic [N_BIDDERS-1:0]         retract,
  input  logic [N_BIDDERS*BID_W-1:0]   bid_amt,
  input  logic [3:0]                   c_op,
  input  logic [BAL_W-1:0]             c_data,
  input  logic                         c_start,
  output logic [N_BIDDERS-1:0]         ack,
  output logic [2*N_BIDDERS-1:0]       bid_err,
  output logic [N_BIDDERS*BAL_W-1:0]   balance,
  output logic [N_BIDDERS-1:0]         win,
  output logic                         ready,
  output logic [2:0]                   err,
  output logic                         round_over,
  output logic [BAL_W-1:0]             max_bid
);
  localparam int SEL_W = (N_BIDDERS > 1) ? $clog2(N_BIDDERS) : 1;

  localparam logic [3:0] OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_SETSEL = 4'd3, OP_LOADBAL = 4'd4,
                         OP_SETMASK = 4'd6, OP_SETTIMER = 4'd7, OP_BIDCHARGE = 4'd8;
  localparam logic [2:0] ERR_KEY = 3'b001, ERR_UNLOCKED = 3'b010, ERR_START = 3'b011,
                         ERR_OP = 3'b100, ERR_TIE = 3'b101;

  typedef enum logic [2:0] {UNLOCKED, LOCKED, ACTIVE, ROUND_OVER, LOCKOUT} state_t;
  state_t state, next_state;

  logic [BAL_W-1:0] bal_q [N_BIDDERS], bal_n [N_BIDDERS];
  logic [BAL_W-1:0] work_q [N_BIDDERS], work_n [N_BIDDERS];
  logic [BAL_W-1:0] total_q [N_BIDDERS], total_n [N_BIDDERS];
  logic [BAL_W-1:0] charge_q [N_BIDDERS], charge_n [N_BIDDERS];
  logic [BID_W-1:0] last_q [N_BIDDERS], last_n [N_BIDDERS];
  logic [N_BIDDERS-1:0] mask_q, mask_n;
  logic [3:0] timer_q, timer_n, lock_cnt_q, lock_cnt_n;
  logic [BAL_W-1:0] key_q, key_n, cost_q, cost_n;
  logic [SEL_W-1:0] sel_q, sel_n;

  logic [N_BIDDERS-1:0] ack_n, win_n;
  logic [2*N_BIDDERS-1:0] bid_err_n;
  logic [2:0] err_n;
  logic round_over_n, ready_n;
  logic [BAL_W-1:0] max_n;

  logic key_ok;
  logic [BAL_W-1:0] top;
  logic [4:0] top_cnt;
  logic [SEL_W-1:0] first_idx;
  logic found, have_win;
  logic [BID_W-1:0] amt;
  logic [BAL_W:0] need;

  assign key_ok = (c_data == key_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNLOCKED;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      UNLOCKED: if (c_op == OP_LOCK) next_state = LOCKED;
      LOCKED, ROUND_OVER: begin
        if (c_start)                 next_state = ACTIVE;
        else if (c_op == OP_UNLOCK)  next_state = key_ok ? UNLOCKED : LOCKOUT;
        else                         next_state = LOCKED;
      end
      ACTIVE:  if (!c_start) next_state = ROUND_OVER;
      LOCKOUT: if (lock_cnt_q <= 4'd1) next_state = LOCKED;
      default: next_state = UNLOCKED;
    endcase
  end

  // Winner search over the settled totals: highest value, how many share it, lowest index holding it.
  always_comb begin
    top = '0;
    top_cnt = '0;
    first_idx = '0;
    found = 1'b0;
    for (int i = 0; i < N_BIDDERS; i++)
      if (total_q[i] > top) top = total_q[i];
    for (int i = 0; i < N_BIDDERS; i++)
      if (total_q[i] == top) begin
        top_cnt = top_cnt + 5'd1;
        if (!found) begin
          first_idx = SEL_W'(i);
          found = 1'b1;
        end
      end
`ifdef BIDS_TIE_LOWEST_EN
    have_win = (top != '0) && (top_cnt != 5'd0);
`else
    have_win = (top != '0) && (top_cnt == 5'd1);
`endif
  end

  always_comb begin
    bal_n = bal_q;
    work_n = work_q;
    total_n = total_q;
    charge_n = charge_q;
    last_n = last_q;
    mask_n = mask_q;
    timer_n = timer_q;
    key_n = key_q;
    cost_n = cost_q;
    sel_n = sel_q;
    lock_cnt_n = lock_cnt_q;
    ack_n = '0;
    bid_err_n = '0;
    win_n = '0;
    err_n = 3'b000;
    round_over_n = 1'b0;
    max_n = '0;
    amt = '0;
    need = '0;

    if (state == UNLOCKED) begin
      if (c_start) err_n = ERR_START;
      case (c_op)
        4'd0:         ;
        OP_UNLOCK:    err_n = ERR_UNLOCKED;
        OP_LOCK:      key_n = c_data;
        OP_SETSEL:    sel_n = SEL_W'(c_data % BAL_W'(N_BIDDERS));
        OP_LOADBAL:
          for (int i = 0; i < N_BIDDERS; i++)
            if (sel_q == SEL_W'(i)) bal_n[i] = c_data;
        OP_SETMASK:   mask_n = c_data[N_BIDDERS-1:0];
        OP_SETTIMER:  timer_n = c_data[3:0];
        OP_BIDCHARGE: cost_n = c_data;
        default:      err_n = ERR_OP;
      endcase
    end else if (state == LOCKOUT) begin
      lock_cnt_n = lock_cnt_q - 4'd1;
    end else if (c_op >= OP_SETSEL) begin
      err_n = ERR_OP;
    end else if (c_op == OP_UNLOCK && state != ACTIVE && !c_start && !key_ok) begin
      err_n = ERR_KEY;
      lock_cnt_n = (timer_q == 4'd0) ? 4'd1 : timer_q;
    end

    if ((state == LOCKED || state == ROUND_OVER) && c_start)
      for (int i = 0; i < N_BIDDERS; i++) begin
        work_n[i] = bal_q[i];
        total_n[i] = '0;
        charge_n[i] = '0;
        last_n[i] = '0;
      end

    // Bidders are only serviced while the round is live; rejected requests leave round state untouched.
    for (int i = 0; i < N_BIDDERS; i++) begin
      amt = bid_amt[i*BID_W +: BID_W];
      need = {1'b0, BAL_W'(amt)} + {1'b0, cost_q};
      if (bid[i] || retract[i]) begin
        if (!(state == ACTIVE && c_start)) bid_err_n[2*i +: 2] = 2'b01;
        else if (!mask_q[i] || (bid[i] && retract[i])) bid_err_n[2*i +: 2] = 2'b11;
        else if (bid[i]) begin
          if ({1'b0, work_q[i]} < need) bid_err_n[2*i +: 2] = 2'b10;
          else begin
            work_n[i] = work_q[i] - need[BAL_W-1:0];
            charge_n[i] = charge_q[i] + cost_q;
            total_n[i] = total_q[i] + BAL_W'(amt);
            last_n[i] = amt;
            ack_n[i] = 1'b1;
          end
        end else if (last_q[i] == '0) bid_err_n[2*i +: 2] = 2'b11;
        else begin
          work_n[i] = work_q[i] + BAL_W'(last_q[i]);
          total_n[i] = total_q[i] - BAL_W'(last_q[i]);
          last_n[i] = '0;
        end
      end
    end

    // Settlement: winner commits its working balance, everyone else only pays the bid charges.
    if (state == ACTIVE && !c_start) begin
      round_over_n = 1'b1;
      if (!have_win) err_n = ERR_TIE;
      for (int i = 0; i < N_BIDDERS; i++)
        if (have_win && first_idx == SEL_W'(i)) begin
          bal_n[i] = work_q[i];
          win_n[i] = 1'b1;
        end else begin
          bal_n[i] = bal_q[i] - charge_q[i];
        end
    end

    if (next_state == ACTIVE || next_state == ROUND_OVER)
      for (int i = 0; i < N_BIDDERS; i++)
        if (total_n[i] > max_n) max_n = total_n[i];
  end

  assign ready_n = (next_state != LOCKOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BIDDERS; i++) begin
        bal_q[i] <= '0;
        work_q[i] <= '0;
        total_q[i] <= '0;
        charge_q[i] <= '0;
        last_q[i] <= '0;
      end
      mask_q <= '1;
      timer_q <= 4'd15;
      lock_cnt_q <= '0;
      key_q <= '0;
      cost_q <= BAL_W'(1);
      sel_q <= '0;
      ack <= '0;
      bid_err <= '0;
      win <= '0;
      ready <= 1'b0;
      err <= 3'b000;
      round_over <= 1'b0;
      max_bid <= '0;
    end else begin
      bal_q <= bal_n;
      work_q <= work_n;
      total_q <= total_n;
      charge_q <= charge_n;
      last_q <= last_n;
      mask_q <= mask_n;
      timer_q <= timer_n;
      lock_cnt_q <= lock_cnt_n;
      key_q <= key_n;
      cost_q <= cost_n;
      sel_q <= sel_n;
      ack <= ack_n;
      bid_err <= bid_err_n;
      win <= win_n;
      ready <= ready_n;
      err <= err_n;
      round_over <= round_over_n;
      max_bid <= max_n;
    end
  end

  for (genvar g = 0; g < N_BIDDERS; g++) begin : g_bal
    assign balance[g*BAL_W +: BAL_W] = bal_q[g];
  end
endmodule

// File: tb/tb_bid_controller_n.sv
// Scoreboard bench for bid_controller_n (3 bidders): directed host/bidder vectors with hand-computed responses.
// Tie expectations follow BIDS_TIE_LOWEST_EN when it is defined.
module tb_bid_controller_n;
  localparam int N = 3, BW = 16, AW = 32;
  localparam logic [7:0] M_ACK = 8'h01, M_BERR = 8'h02, M_BAL = 8'h04, M_WIN = 8'h08,
                         M_RDY = 8'h10, M_ERR = 8'h20, M_RO = 8'h40, M_MAX = 8'h80, M_ALL = 8'hFF;
  localparam logic [3:0] NOP = 4'd0, UNLOCK = 4'd1, LOCK = 4'd2, SETSEL = 4'd3, LOADBAL = 4'd4,
                         SETMASK = 4'd6, SETTIMER = 4'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] bid = '0, retract = '0;
  logic [N*BW-1:0] bid_amt = '0;
  logic [3:0] c_op = '0;
  logic [AW-1:0] c_data = '0;
  logic c_start = 1'b0;
  logic [N-1:0] ack, win;
  logic [2*N-1:0] bid_err;
  logic [N*AW-1:0] balance;
  logic ready, round_over;
  logic [2:0] err;
  logic [AW-1:0] max_bid;

  bid_controller_n #(.N_BIDDERS(N), .BID_W(BW), .BAL_W(AW)) dut (
    .clk(clk), .reset(reset), .bid(bid), .retract(retract), .bid_amt(bid_amt),
    .c_op(c_op), .c_data(c_data), .c_start(c_start), .ack(ack), .bid_err(bid_err),
    .balance(balance), .win(win), .ready(ready), .err(err), .round_over(round_over),
    .max_bid(max_bid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    string name;
    logic [7:0] m;
    logic [2:0] ack;
    logic [5:0] berr;
    logic [95:0] bal;
    logic [2:0] win;
    logic rdy;
    logic [2:0] err;
    logic ro;
    logic [31:0] mx;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] bals(input int a, input int b, input int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic check_output(input string nm, input string f, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: actual=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] data, input logic start,
                                input logic [2:0] b, input logic [2:0] r,
                                input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    @(negedge clk);
    c_op = op;
    c_data = data;
    c_start = start;
    bid = b;
    retract = r;
    bid_amt = {a2, a1, a0};
  endtask

  task automatic host(input logic [3:0] op, input logic [31:0] data, input logic start);
    apply_stimulus(op, data, start, 3'b000, 3'b000, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic bidders(input logic [2:0] b, input logic [2:0] r,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    apply_stimulus(NOP, 32'd0, 1'b1, b, r, a0, a1, a2);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] m, input logic [2:0] a, input logic [5:0] be,
                            input logic [95:0] bl, input logic [2:0] w, input logic rd, input logic [2:0] er,
                            input logic ro, input logic [31:0] mx);
    exp_t e;
    e.due = cyc + 1;
    e.name = nm;
    e.m = m;
    e.ack = a;
    e.berr = be;
    e.bal = bl;
    e.win = w;
    e.rdy = rd;
    e.err = er;
    e.ro = ro;
    e.mx = mx;
    exp_q.push_back(e);
  endtask

  // Monitor: pops whatever response is due this cycle and compares the fields it cares about.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.m & M_ACK)  check_output(e.name, "ack", 96'(ack), 96'(e.ack));
        if (e.m & M_BERR) check_output(e.name, "bid_err", 96'(bid_err), 96'(e.berr));
        if (e.m & M_BAL)  check_output(e.name, "balance", balance, e.bal);
        if (e.m & M_WIN)  check_output(e.name, "win", 96'(win), 96'(e.win));
        if (e.m & M_RDY)  check_output(e.name, "ready", 96'(ready), 96'(e.rdy));
        if (e.m & M_ERR)  check_output(e.name, "err", 96'(err), 96'(e.err));
        if (e.m & M_RO)   check_output(e.name, "round_over", 96'(round_over), 96'(e.ro));
        if (e.m & M_MAX)  check_output(e.name, "max_bid", 96'(max_bid), 96'(e.mx));
      end
    end
  end

  initial begin : watchdog
    #100000;
    errors++;
    $display("[TB] FAIL timeout: actual=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    logic [2:0] tie_win, tie_err;
    int tie_b0;
`ifdef BIDS_TIE_LOWEST_EN
    tie_win = 3'b001; tie_err = 3'b000; tie_b0 = 57;
`else
    tie_win = 3'b000; tie_err = 3'b101; tie_b0 = 97;
`endif

    host(NOP, 0, 0);
    expect_out("reset_state", M_ALL, 0, 0, '0, 0, 0, 0, 0, 0);
    host(NOP, 0, 0);
    reset = 1'b0;
    expect_out("ready_after_reset", M_RDY | M_ERR | M_BAL, 0, 0, '0, 0, 1, 0, 0, 0);

    host(SETSEL, 0, 0);     expect_out("setsel0", M_ERR, 0, 0, '0, 0, 1, 0, 0, 0);
    host(LOADBAL, 100, 0);  expect_out("load0", M_BAL | M_ERR, 0, 0, bals(100, 0, 0), 0, 1, 0, 0, 0);
    host(SETSEL, 4, 0);
    host(LOADBAL, 200, 0);  expect_out("load1_mod", M_BAL, 0, 0, bals(100, 200, 0), 0, 1, 0, 0, 0);
    host(SETSEL, 2, 0);
    host(LOADBAL, 300, 0);
    host(SETTIMER, 4, 0);
    host(UNLOCK, 0, 0);     expect_out("unlock_when_unlocked", M_ERR, 0, 0, '0, 0, 1, 3'b010, 0, 0);
    host(4'd5, 0, 0);       expect_out("invalid_op", M_ERR, 0, 0, '0, 0, 1, 3'b100, 0, 0);
    host(LOCK, 32'h55, 0);  expect_out("lock", M_BAL | M_RDY | M_ERR, 0, 0, bals(100, 200, 300), 0, 1, 0, 0, 0);

    host(SETMASK, 1, 0);    expect_out("cmd_while_locked", M_ERR, 0, 0, '0, 0, 1, 3'b100, 0, 0);
    host(UNLOCK, 32'h54, 0); expect_out("bad_key", M_RDY | M_ERR, 0, 0, '0, 0, 0, 3'b001, 0, 0);
    host(NOP, 0, 0);        expect_out("lockout_c1", M_RDY | M_ERR, 0, 0, '0, 0, 0, 0, 0, 0);
    host(UNLOCK, 32'h55, 0); expect_out("lockout_c2_ignore", M_RDY | M_ERR, 0, 0, '0, 0, 0, 0, 0, 0);
    host(NOP, 0, 0);        expect_out("lockout_c3", M_RDY, 0, 0, '0, 0, 0, 0, 0, 0);
    host(NOP, 0, 0);        expect_out("lockout_end", M_RDY, 0, 0, '0, 0, 1, 0, 0, 0);
    host(UNLOCK, 32'h55, 0); expect_out("good_key", M_RDY | M_ERR, 0, 0, '0, 0, 1, 0, 0, 0);
    host(NOP, 0, 1);        expect_out("start_unlocked", M_ERR, 0, 0, '0, 0, 1, 3'b011, 0, 0);
    host(LOCK, 32'h55, 0);  expect_out("relock", M_ERR, 0, 0, '0, 0, 1, 0, 0, 0);

    bidders(3'b001, 3'b000, 5, 0, 0);
    expect_out("bid_inactive", M_ACK | M_BERR, 0, 6'b000001, '0, 0, 1, 0, 0, 0);
    bidders(3'b011, 3'b000, 50, 60, 0);
    expect_out("bids_xy", M_ACK | M_BERR | M_MAX, 3'b011, 0, '0, 0, 1, 0, 0, 60);
    host(NOP, 0, 0);
    expect_out("settle_y_wins", M_ALL, 0, 0, bals(99, 139, 300), 3'b010, 1, 0, 1, 60);
    host(NOP, 0, 0);
    expect_out("ro_pulse", M_RO | M_WIN | M_MAX, 0, 0, '0, 0, 1, 0, 0, 0);

    host(NOP, 0, 1);
    bidders(3'b001, 3'b000, 30, 0, 0);
    expect_out("bid_x30", M_ACK | M_MAX, 3'b001, 0, '0, 0, 1, 0, 0, 30);
    bidders(3'b000, 3'b001, 0, 0, 0);
    expect_out("retract_ok", M_ACK | M_BERR | M_MAX, 0, 0, '0, 0, 1, 0, 0, 0);
    bidders(3'b000, 3'b001, 0, 0, 0);
    expect_out("retract_twice", M_BERR, 0, 6'b000011, '0, 0, 1, 0, 0, 0);
    bidders(3'b001, 3'b001, 5, 0, 0);
    expect_out("bid_and_retract", M_ACK | M_BERR, 0, 6'b000011, '0, 0, 1, 0, 0, 0);
    host(NOP, 0, 0);
    expect_out("settle_no_bids", M_ALL, 0, 0, bals(98, 139, 300), 0, 1, 3'b101, 1, 0);

    host(NOP, 0, 1);
    expect_out("restart_from_ro", M_RO | M_ERR, 0, 0, '0, 0, 1, 0, 0, 0);
    bidders(3'b011, 3'b000, 40, 40, 0);
    expect_out("tie_bids", M_ACK | M_MAX, 3'b011, 0, '0, 0, 1, 0, 0, 40);
    bidders(3'b010, 3'b000, 0, 250, 0);
    expect_out("insufficient", M_ACK | M_BERR, 0, 6'b001000, '0, 0, 1, 0, 0, 0);
    bidders(3'b001, 3'b000, 57, 0, 0);
    expect_out("one_short", M_ACK | M_BERR, 0, 6'b000010, '0, 0, 1, 0, 0, 0);
    host(NOP, 0, 0);
    expect_out("settle_tie", M_ALL, 0, 0, bals(tie_b0, 138, 300), tie_win, 1, tie_err, 1, 40);

    host(UNLOCK, 32'h55, 0); expect_out("unlock_from_ro", M_ERR | M_RDY, 0, 0, '0, 0, 1, 0, 0, 0);
    host(SETMASK, 6, 0);    expect_out("setmask", M_ERR, 0, 0, '0, 0, 1, 0, 0, 0);
    host(LOCK, 32'h55, 0);
    host(NOP, 0, 1);
    bidders(3'b001, 3'b000, 10, 0, 0);
    expect_out("masked_bid", M_ACK | M_BERR, 0, 6'b000011, '0, 0, 1, 0, 0, 0);
    bidders(3'b100, 3'b000, 0, 0, 299);
    expect_out("exact_funds", M_ACK | M_BERR | M_MAX, 3'b100, 0, '0, 0, 1, 0, 0, 299);
    bidders(3'b000, 3'b000, 0, 0, 0);
    reset = 1'b1;
    expect_out("reset_midround", M_ALL, 0, 0, '0, 0, 0, 0, 0, 0);
    host(NOP, 0, 0);
    reset = 1'b0;
    expect_out("post_reset", M_ALL, 0, 0, '0, 0, 1, 0, 0, 0);
    host(UNLOCK, 0, 0);
    expect_out("unlocked_after_reset", M_ERR, 0, 0, '0, 0, 1, 3'b010, 0, 0);
    host(NOP, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
